// File: rtl/legv8_imm_pkg.sv
// Shared format codes, opcode match values and buffer entry type for the LEGv8 immediate extender.
// Optional feature macro used by the decoder: LEGV8_MOVW_SHIFT_EN.
package legv8_imm_pkg;

   localparam int IMM_W = 64;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_D    = 3'd1,
      FMT_I    = 3'd2,
      FMT_B    = 3'd3,
      FMT_CB   = 3'd4,
      FMT_IW   = 3'd5
   } fmt_t;

   localparam logic [5:0] OP_B      = 6'h05;
   localparam logic [5:0] OP_BL     = 6'h25;

   localparam logic [7:0] OP_CBZ    = 8'hB4;
   localparam logic [7:0] OP_CBNZ   = 8'hB5;
   localparam logic [7:0] OP_BCOND  = 8'h54;

   localparam logic [8:0] OP_MOVZ   = 9'h1A5;
   localparam logic [8:0] OP_MOVK   = 9'h1E5;

   // I-format opcodes are quoted as 11-bit values (0x488 ...); only the top 10 bits are fixed.
   localparam logic [9:0] OP_ADDI   = 10'h244;
   localparam logic [9:0] OP_ADDIS  = 10'h2C4;
   localparam logic [9:0] OP_SUBI   = 10'h344;
   localparam logic [9:0] OP_SUBIS  = 10'h3C4;
   localparam logic [9:0] OP_ANDI   = 10'h248;
   localparam logic [9:0] OP_ORRI   = 10'h2C8;
   localparam logic [9:0] OP_EORI   = 10'h348;

   localparam logic [10:0] OP_LDUR   = 11'h7C2;
   localparam logic [10:0] OP_STUR   = 11'h7C0;
   localparam logic [10:0] OP_LDURB  = 11'h1C2;
   localparam logic [10:0] OP_STURB  = 11'h1C0;
   localparam logic [10:0] OP_LDURH  = 11'h3C2;
   localparam logic [10:0] OP_STURH  = 11'h3C0;
   localparam logic [10:0] OP_LDURSW = 11'h5C4;
   localparam logic [10:0] OP_STURW  = 11'h5C0;

   typedef struct packed {
      logic [IMM_W-1:0] imm;
      logic [2:0]       fmt;
   } entry_t;

endpackage

// File: rtl/legv8_imm_decode.sv
// Combinational LEGv8 format decode, immediate extraction and extension to DATA_W.
// LEGV8_MOVW_SHIFT_EN defined: MOVZ/MOVK immediates are pre-shifted by 16*hw.
module legv8_imm_decode
   import legv8_imm_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int BR_SHIFT = 1
) (
   input  logic [31:0]       instr,
   output logic [DATA_W-1:0] imm,
   output logic [2:0]        fmt
);

   fmt_t              dec_fmt;
   logic [DATA_W-1:0] iw_imm;
   logic              unused_rd;

   assign unused_rd = ^instr[4:0];
   assign fmt       = dec_fmt;

   function automatic logic [DATA_W-1:0] scale_br(input logic [DATA_W-1:0] v);
      return (BR_SHIFT != 0) ? (v << 2) : v;
   endfunction

`ifdef LEGV8_MOVW_SHIFT_EN
   logic [63:0] mov_wide;
   assign mov_wide = 64'(instr[20:5]) << {instr[22:21], 4'b0000};
   assign iw_imm   = mov_wide[DATA_W-1:0];
`else
   assign iw_imm   = {{(DATA_W-16){1'b0}}, instr[20:5]};
`endif

   always_comb begin
      dec_fmt = FMT_NONE;
      imm     = '0;
      if (instr[31:26] inside {OP_B, OP_BL}) begin
         dec_fmt = FMT_B;
         imm     = scale_br({{(DATA_W-26){instr[25]}}, instr[25:0]});
      end else if (instr[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
         dec_fmt = FMT_CB;
         imm     = scale_br({{(DATA_W-19){instr[23]}}, instr[23:5]});
      end else if (instr[31:23] inside {OP_MOVZ, OP_MOVK}) begin
         dec_fmt = FMT_IW;
         imm     = iw_imm;
      end else if (instr[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                        OP_ANDI, OP_ORRI, OP_EORI}) begin
         dec_fmt = FMT_I;
         imm     = {{(DATA_W-12){1'b0}}, instr[21:10]};
      end else if (instr[31:21] inside {OP_LDUR, OP_STUR, OP_LDURB, OP_STURB,
                                        OP_LDURH, OP_STURH, OP_LDURSW, OP_STURW}) begin
         dec_fmt = FMT_D;
         imm     = {{(DATA_W-9){instr[20]}}, instr[20:12]};
      end
   end

endmodule

// File: rtl/legv8_imm_extend_buf.sv
// Immediate extend stage with a 2-entry output buffer so decode backpressure never drops an instruction.
// Optional feature macro (in legv8_imm_decode): LEGV8_MOVW_SHIFT_EN.
module legv8_imm_extend_buf
   import legv8_imm_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int BR_SHIFT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic [2:0]        out_fmt
);

   logic [DATA_W-1:0] dec_imm;
   logic [2:0]        dec_fmt;
   entry_t            new_entry;
   entry_t            head;
   entry_t            tail;
   logic [1:0]        count;
   logic              push;
   logic              pop;

   legv8_imm_decode #(
      .DATA_W   (DATA_W),
      .BR_SHIFT (BR_SHIFT)
   ) u_decode (
      .instr (in_instr),
      .imm   (dec_imm),
      .fmt   (dec_fmt)
   );

   assign new_entry.imm = IMM_W'(dec_imm);
   assign new_entry.fmt = dec_fmt;

   // in_ready depends only on the registered count, never on out_ready.
   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_imm   = head.imm[DATA_W-1:0];
   assign out_fmt   = head.fmt;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= new_entry;
               else               tail <= new_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Push with pop only happens at count 1: the new entry becomes the head.
               head <= new_entry;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_legv8_imm_extend_buf.sv
// Directed self-checking bench for legv8_imm_extend_buf (BR_SHIFT=1 and BR_SHIFT=0 instances).
module tb_legv8_imm_extend_buf;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_imm;
   logic [2:0]  out_fmt;

   logic        raw_in_ready;
   logic        raw_out_valid;
   logic [63:0] raw_out_imm;
   logic [2:0]  raw_out_fmt;

   int vectors;
   int miscompares;

   localparam logic [31:0] I_LDUR   = 32'hF85F8041;
   localparam logic [31:0] I_B_M1   = 32'h17FFFFFF;
   localparam logic [31:0] I_CBZ    = 32'hB4000060;
   localparam logic [31:0] I_ADDI   = 32'h913FFC41;
   localparam logic [31:0] I_ZERO   = 32'h00000000;
   localparam logic [31:0] I_ONES   = 32'hFFFFFFFF;
   localparam logic [31:0] I_MOVZ   = 32'hD2D579A3;
   localparam logic [31:0] I_CBNZ   = 32'hB5FFFFC1;
   localparam logic [31:0] I_STUR   = 32'hF80FF0C5;
   localparam logic [31:0] I_BL     = 32'h94001000;
   localparam logic [31:0] I_ORRI   = 32'hB2200000;
   localparam logic [31:0] I_LDURSW = 32'hB8900000;

`ifdef LEGV8_MOVW_SHIFT_EN
   localparam logic [63:0] MOVZ_IMM = 64'h0000_ABCD_0000_0000;
`else
   localparam logic [63:0] MOVZ_IMM = 64'h0000_0000_0000_ABCD;
`endif

   legv8_imm_extend_buf #(
      .DATA_W   (64),
      .BR_SHIFT (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_fmt   (out_fmt)
   );

   legv8_imm_extend_buf #(
      .DATA_W   (64),
      .BR_SHIFT (0)
   ) dut_raw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (raw_in_ready),
      .in_instr  (in_instr),
      .out_valid (raw_out_valid),
      .out_ready (out_ready),
      .out_imm   (raw_out_imm),
      .out_fmt   (raw_out_fmt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [2:0] exp_fmt,
                               input logic [63:0] exp_imm);
      vectors++;
      assert (out_valid === 1'b1 && out_fmt === exp_fmt && out_imm === exp_imm) else begin
         miscompares++;
         $error("[TB] FAIL %s: got valid=%b fmt=%0d imm=%h, expected valid=1 fmt=%0d imm=%h",
                tag, out_valid, out_fmt, out_imm, exp_fmt, exp_imm);
      end
   endtask

   task automatic check_raw(input string tag, input logic [2:0] exp_fmt,
                            input logic [63:0] exp_imm);
      vectors++;
      assert (raw_out_valid === 1'b1 && raw_out_fmt === exp_fmt && raw_out_imm === exp_imm) else begin
         miscompares++;
         $error("[TB] FAIL %s: got valid=%b fmt=%0d imm=%h, expected valid=1 fmt=%0d imm=%h",
                tag, raw_out_valid, raw_out_fmt, raw_out_imm, exp_fmt, exp_imm);
      end
   endtask

   task automatic check_bit(input string tag, input logic observed, input logic expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   // Present one instruction with out_ready high; when the buffer held at most
   // one entry, the new entry is the head right after the accepting edge.
   task automatic apply_stimulus(input logic [31:0] instr);
      in_valid  = 1'b1;
      in_instr  = instr;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_instr    = 32'h0;
      out_ready   = 1'b0;

      #2;
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_imm_zero", (out_imm == 64'h0), 1'b1);
      check_bit("rst_fmt_none", (out_fmt == 3'd0), 1'b1);
      check_bit("rst_raw_in_ready", raw_in_ready, 1'b1);
      #10;
      rst_n = 1'b1;

      // Back-to-back stream through the single-entry steady state.
      apply_stimulus(I_LDUR);
      check_output("ldur_neg8", 3'd1, 64'hFFFF_FFFF_FFFF_FFF8);
      apply_stimulus(I_B_M1);
      check_output("b_minus1", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
      check_raw("b_minus1_raw", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      apply_stimulus(I_CBZ);
      check_output("cbz_3", 3'd4, 64'h0000_0000_0000_000C);
      check_raw("cbz_3_raw", 3'd4, 64'h0000_0000_0000_0003);
      apply_stimulus(I_ADDI);
      check_output("addi_4095", 3'd2, 64'h0000_0000_0000_0FFF);
      apply_stimulus(I_ZERO);
      check_output("unknown_zero", 3'd0, 64'h0);
      apply_stimulus(I_ONES);
      check_output("unknown_ones", 3'd0, 64'h0);
      apply_stimulus(I_MOVZ);
      check_output("movz_lsl32", 3'd5, MOVZ_IMM);
      apply_stimulus(I_CBNZ);
      check_output("cbnz_m2", 3'd4, 64'hFFFF_FFFF_FFFF_FFF8);
      check_raw("cbnz_m2_raw", 3'd4, 64'hFFFF_FFFF_FFFF_FFFE);
      apply_stimulus(I_STUR);
      check_output("stur_255", 3'd1, 64'h0000_0000_0000_00FF);
      apply_stimulus(I_BL);
      check_output("bl_0x1000", 3'd3, 64'h0000_0000_0000_4000);
      check_raw("bl_0x1000_raw", 3'd3, 64'h0000_0000_0000_1000);
      apply_stimulus(I_ORRI);
      check_output("orri_0x800", 3'd2, 64'h0000_0000_0000_0800);
      apply_stimulus(I_LDURSW);
      check_output("ldursw_m256", 3'd1, 64'hFFFF_FFFF_FFFF_FF00);
      tick();
      check_bit("drained_valid", out_valid, 1'b0);

      // Backpressure: three offers with out_ready low, then release.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = I_LDUR;
      tick();
      check_bit("bp_ready_after_1", in_ready, 1'b1);
      check_output("bp_head_a", 3'd1, 64'hFFFF_FFFF_FFFF_FFF8);
      in_instr  = I_CBZ;
      tick();
      check_bit("bp_ready_after_2", in_ready, 1'b0);
      in_instr  = I_ADDI;
      tick();
      check_bit("bp_ready_held", in_ready, 1'b0);
      check_output("bp_head_stable", 3'd1, 64'hFFFF_FFFF_FFFF_FFF8);
      out_ready = 1'b1;
      tick();
      check_output("bp_head_b", 3'd4, 64'h0000_0000_0000_000C);
      check_bit("bp_ready_reopen", in_ready, 1'b1);
      tick();
      in_valid  = 1'b0;
      check_output("bp_head_c", 3'd2, 64'h0000_0000_0000_0FFF);
      tick();
      check_bit("bp_empty", out_valid, 1'b0);

      // Fill to two entries, then reset asynchronously between edges.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = I_STUR;
      tick();
      in_instr  = I_BL;
      tick();
      in_valid  = 1'b0;
      check_bit("full_ready_low", in_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("arst_valid", out_valid, 1'b0);
      check_bit("arst_ready", in_ready, 1'b1);
      check_bit("arst_imm_zero", (out_imm == 64'h0), 1'b1);
      check_bit("arst_fmt_none", (out_fmt == 3'd0), 1'b1);
      #3;
      rst_n = 1'b1;
      apply_stimulus(I_B_M1);
      check_output("post_rst_b", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      check_bit("post_rst_drain", out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
